// File: rtl/mbus_uart.sv
// Memory-mapped byte UART: 4-entry TX FIFO, single-byte RX holding register,
// programmable baud divisor. Reads are side-effect free and combinational.
`timescale 1ns/1ps
module mbus_uart #(
   parameter int          WIDTH    = 32,
   parameter logic [15:0] BAUD_DIV = 16'd16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cs,
   input  logic [1:0]       addr,
   input  logic [WIDTH-1:0] din,
   input  logic             wen,
   output logic [WIDTH-1:0] dout,
   output logic             txd,
   input  logic             rxd
);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic [15:0] brd_reg;
   logic [15:0] eff_div;
   logic [15:0] bit_reload;
   logic [15:0] half_reload;

   logic [7:0]  fifo_mem [0:3];
   logic [1:0]  wr_ptr_reg;
   logic [1:0]  rd_ptr_reg;
   logic [2:0]  count_reg;

   state_t      tx_state_reg;
   logic [15:0] tx_cnt_reg;
   logic [7:0]  tx_shift_reg;
   logic [2:0]  tx_bit_reg;
   logic        txd_reg;

   state_t      rx_state_reg;
   logic        rx_s1_reg;
   logic        rx_s2_reg;
   logic [15:0] rx_cnt_reg;
   logic [7:0]  rx_shift_reg;
   logic [2:0]  rx_bit_reg;
   logic [7:0]  rx_data_reg;
   logic        rx_full_reg;
   logic        overrun_reg;
   logic        frame_err_reg;

   logic wr_en, dr_wr, stat_wr, brd_wr;
   logic tx_full, tx_empty, tx_idle, tx_bound, push, pop;
   logic rx_bound, rx_done, rx_good, rx_bad, rx_load;
   logic ack_full, ack_ov, ack_fe;
   logic unused_din;

   assign unused_din = &{1'b0, din[WIDTH-1:16]};

   assign wr_en   = cs & wen;
   assign dr_wr   = wr_en && (addr == 2'd0);
   assign stat_wr = wr_en && (addr == 2'd1);
   assign brd_wr  = wr_en && (addr == 2'd2);

   assign eff_div     = (brd_reg < 16'd2) ? 16'd2 : brd_reg;
   assign bit_reload  = eff_div - 16'd1;
   assign half_reload = (eff_div >> 1) - 16'd1;

   assign tx_full  = (count_reg == 3'd4);
   assign tx_empty = (count_reg == 3'd0);
   assign tx_bound = (tx_cnt_reg == 16'd0);
   assign tx_idle  = tx_empty && (tx_state_reg == IDLE);
   assign push     = dr_wr & ~tx_full;
   // Popping straight out of STOP keeps back-to-back frames gapless.
   assign pop      = ~tx_empty && ((tx_state_reg == IDLE) ||
                                   ((tx_state_reg == STOP) && tx_bound));

   assign ack_full = stat_wr & din[0];
   assign ack_ov   = stat_wr & din[3];
   assign ack_fe   = stat_wr & din[4];

   assign rx_bound = (rx_cnt_reg == 16'd0);
   assign rx_done  = (rx_state_reg == STOP) && rx_bound;
   assign rx_good  = rx_done & rx_s2_reg;
   assign rx_bad   = rx_done & ~rx_s2_reg;
   assign rx_load  = rx_good & (~rx_full_reg | ack_full);

   assign txd = txd_reg;

   always_comb begin
      dout = '0;
      if (cs) begin
         case (addr)
            2'd0:    dout[7:0]  = rx_data_reg;
            2'd1:    dout[7:0]  = {count_reg, frame_err_reg, overrun_reg,
                                   tx_full, tx_idle, rx_full_reg};
            2'd2:    dout[15:0] = brd_reg;
            default: dout = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr_reg] <= din[7:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         brd_reg    <= BAUD_DIV;
         wr_ptr_reg <= 2'd0;
         rd_ptr_reg <= 2'd0;
         count_reg  <= 3'd0;
      end else begin
         if (brd_wr)
            brd_reg <= din[15:0];
         if (push)
            wr_ptr_reg <= wr_ptr_reg + 2'd1;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + 2'd1;
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 3'd1;
            2'b01:   count_reg <= count_reg - 3'd1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_state_reg <= IDLE;
         tx_cnt_reg   <= 16'd0;
         tx_shift_reg <= 8'd0;
         tx_bit_reg   <= 3'd0;
         txd_reg      <= 1'b1;
      end else begin
         case (tx_state_reg)
            IDLE: begin
               if (pop) begin
                  tx_shift_reg <= fifo_mem[rd_ptr_reg];
                  tx_cnt_reg   <= bit_reload;
                  txd_reg      <= 1'b0;
                  tx_state_reg <= START;
               end
            end
            START: begin
               if (tx_bound) begin
                  tx_cnt_reg   <= bit_reload;
                  txd_reg      <= tx_shift_reg[0];
                  tx_shift_reg <= tx_shift_reg >> 1;
                  tx_bit_reg   <= 3'd0;
                  tx_state_reg <= DATA;
               end else begin
                  tx_cnt_reg <= tx_cnt_reg - 16'd1;
               end
            end
            DATA: begin
               if (tx_bound) begin
                  tx_cnt_reg <= bit_reload;
                  if (tx_bit_reg == 3'd7) begin
                     txd_reg      <= 1'b1;
                     tx_state_reg <= STOP;
                  end else begin
                     txd_reg      <= tx_shift_reg[0];
                     tx_shift_reg <= tx_shift_reg >> 1;
                     tx_bit_reg   <= tx_bit_reg + 3'd1;
                  end
               end else begin
                  tx_cnt_reg <= tx_cnt_reg - 16'd1;
               end
            end
            STOP: begin
               if (tx_bound) begin
                  if (pop) begin
                     tx_shift_reg <= fifo_mem[rd_ptr_reg];
                     tx_cnt_reg   <= bit_reload;
                     txd_reg      <= 1'b0;
                     tx_state_reg <= START;
                  end else begin
                     tx_state_reg <= IDLE;
                  end
               end else begin
                  tx_cnt_reg <= tx_cnt_reg - 16'd1;
               end
            end
            default: tx_state_reg <= IDLE;
         endcase
      end
   end

   // rx_s2 is the synchronized line; its falling edge is seen as s2=1, s1=0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_s1_reg    <= 1'b1;
         rx_s2_reg    <= 1'b1;
         rx_state_reg <= IDLE;
         rx_cnt_reg   <= 16'd0;
         rx_shift_reg <= 8'd0;
         rx_bit_reg   <= 3'd0;
      end else begin
         rx_s1_reg <= rxd;
         rx_s2_reg <= rx_s1_reg;
         case (rx_state_reg)
            IDLE: begin
               if (rx_s2_reg && !rx_s1_reg) begin
                  rx_cnt_reg   <= half_reload;
                  rx_state_reg <= START;
               end
            end
            START: begin
               if (rx_bound) begin
                  if (rx_s2_reg) begin
                     rx_state_reg <= IDLE;
                  end else begin
                     rx_cnt_reg   <= bit_reload;
                     rx_bit_reg   <= 3'd0;
                     rx_state_reg <= DATA;
                  end
               end else begin
                  rx_cnt_reg <= rx_cnt_reg - 16'd1;
               end
            end
            DATA: begin
               if (rx_bound) begin
                  rx_shift_reg <= {rx_s2_reg, rx_shift_reg[7:1]};
                  rx_cnt_reg   <= bit_reload;
                  if (rx_bit_reg == 3'd7)
                     rx_state_reg <= STOP;
                  else
                     rx_bit_reg <= rx_bit_reg + 3'd1;
               end else begin
                  rx_cnt_reg <= rx_cnt_reg - 16'd1;
               end
            end
            STOP: begin
               if (rx_bound)
                  rx_state_reg <= IDLE;
               else
                  rx_cnt_reg <= rx_cnt_reg - 16'd1;
            end
            default: rx_state_reg <= IDLE;
         endcase
      end
   end

   // A byte completing in the same cycle as an rx_full ack replaces the old one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_data_reg   <= 8'd0;
         rx_full_reg   <= 1'b0;
         overrun_reg   <= 1'b0;
         frame_err_reg <= 1'b0;
      end else begin
         if (rx_load) begin
            rx_data_reg <= rx_shift_reg;
            rx_full_reg <= 1'b1;
         end else if (ack_full) begin
            rx_full_reg <= 1'b0;
         end
         if (rx_good && rx_full_reg && !ack_full)
            overrun_reg <= 1'b1;
         else if (ack_ov)
            overrun_reg <= 1'b0;
         if (rx_bad)
            frame_err_reg <= 1'b1;
         else if (ack_fe)
            frame_err_reg <= 1'b0;
      end
   end
endmodule

// File: doc/mbus_uart.md
# mbus_uart

Memory-bus responder implementing a byte UART with a 4-entry transmit FIFO and a single-byte receive holding register. It sits on the CPU data bus behind the system address decoder. It accepts register writes on the CPU's write-enable strobe and returns read data combinationally in the same cycle. Reads have no side effects, because the bus carries no read strobe and the CPU holds an address across several phases.

## Interface
- WIDTH, 32, bus data width; register data occupies bits [15:0], and upper bits read 0
- BAUD_DIV, 16'd16, reset value of the baud divisor register
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cs  in  1  chip select from the address decoder
- addr  in  2  word register index, taken from the bus address bits [1:0]
- din  in  WIDTH  write data (the CPU's data output)
- wen  in  1  write strobe; the write takes effect at the rising edge when cs&wen
- dout  out  WIDTH  read data, combinational from addr; 0 when cs=0
- txd  out  1  serial transmit line, idle high
- rxd  in  1  serial receive line, asynchronous to clk

## Operation
- Register map:
  - addr 0, DR: read returns {rx_data[7:0]}; write pushes din[7:0] into the TX FIFO.
  - addr 1, STAT: read bits are b0 rx_full, b1 tx_idle (FIFO empty and shifter idle), b2 tx_full, b3 overrun, b4 frame_err, b7:5 tx FIFO count (0..4). Writing 1 to b0, b3 or b4 clears that flag; writing 0 leaves it unchanged.
  - addr 2, BRD: read/write baud divisor, 16 bits. The effective divisor is max(BRD,2).
  - addr 3: reads 0; writes are ignored.
- TX FIFO: 4 entries, with 2-bit read/write pointers that wrap modulo 4 and a 3-bit count.
  - A push while full is dropped silently; the count and contents stay unchanged.
  - A push and a pop in the same cycle both happen, and the count stays unchanged.
- TX FSM states are IDLE, START, DATA, STOP.
  - IDLE: when the FIFO is non-empty, pop the head into the shifter and go to START.
  - START drives txd=0. DATA drives 8 bits, LSB first. STOP drives txd=1.
  - Each state holds one bit time, then STOP returns to IDLE.
- RX path:
  - rxd passes through a 2-flop synchronizer.
  - RX FSM states are IDLE, START, DATA, STOP.
  - IDLE detects the synchronized falling edge. START samples at half a bit time; if the line is high, it returns to IDLE as a glitch. Otherwise sampling continues every bit time for 8 data bits (LSB first), then the stop bit.
  - Stop bit = 1 with rx_full=0: load rx_data and set rx_full.
  - Stop bit = 1 with rx_full=1: discard the byte and set overrun.
  - Stop bit = 0: discard the byte and set frame_err.
  - If a STAT ack of rx_full and a byte completion land in the same cycle, the new byte loads, rx_full stays 1 and overrun is not set.
- Baud timing: TX and RX each own a down-counter. The counter reloads with the effective divisor at every bit boundary, so a BRD write mid-frame takes effect at the next bit boundary.

## Timing
- Reset values:
  - txd=1.
  - rx_data=0, rx_full=0, overrun=0, frame_err=0.
  - FIFO empty with pointers 0, BRD=BAUD_DIV.
  - Both FSMs in IDLE.
  - dout follows addr combinationally: for example, STAT reads 0x02 after reset.
- Register writes are visible on dout one cycle after the write edge.
- TX latency: a DR write at edge N into an empty FIFO with TX idle is popped at edge N+1, and txd falls at N+1.
- TX frame: each bit is exactly D clocks, where D is the effective divisor. A frame lasts 10·D clocks. Back-to-back FIFO bytes produce no idle gap between STOP and the next START.
- RX latency:
  - The falling edge becomes visible 2 clocks after rxd changes (synchronizer).
  - The start-bit check occurs D/2 clocks later (integer divide).
  - rx_full rises 9·D clocks after the start check, at the stop-bit sample.
- Reset asserted mid-frame immediately forces every reset value, and txd goes high with no partial-frame completion.

## Test plan
- Reset: pulse reset, then read STAT and BRD → STAT=0x02, BRD=16, txd=1.
- TX single byte: with BRD=4, write DR=0x55 → txd reads 0 for 4 clocks, then 1,0,1,0,1,0,1,0 for 4 clocks each, then 1; the frame is 40 clocks and STAT.b1 returns to 1.
- FIFO full: with BRD=100, write DR 6 times (0x01..0x06) → the first is popped and the next 4 fill the FIFO, so the 6th is dropped. STAT shows b2=1 and count=4. Exactly 5 frames are transmitted: 0x01..0x05.
- RX and overrun: with BRD=8, drive frame 0xA3 on rxd → rx_full=1 and DR=0xA3. Drive 0x3C without acking → DR stays 0xA3 and overrun=1. Write STAT=0x09 → both flags clear.
- Framing and glitch:
  - Drive an rxd low pulse of 2 clocks at BRD=8 → no state change.
  - Drive frame 0x11 with stop bit 0 → frame_err=1 and rx_full=0.
- Loopback: tie txd→rxd, set BRD=3, write DR=0xF0 → rx_full=1 and DR=0xF0; no overrun or frame_err.
